// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: state encoding and mux select constants for mux_channel_arbiter
package mux_arb_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT0 = 2'd1,
      ARB_GRANT1 = 2'd2
   } arb_state_t;
   localparam logic SEL_CH0 = 1'b0;
   localparam logic SEL_CH1 = 1'b1;
endpackage

// File: rtl/mux2_data_path.sv
// mux2_data_path: pure 2:1 select of data/valid/last
// ports: sel picks channel (0/1); data0/1, valid0/1, last0/1 in; data, valid, last out
module mux2_data_path #(
   parameter int WIDTH = 8
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic             valid0,
   input  logic             valid1,
   input  logic             last0,
   input  logic             last1,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             last
);
   always_comb begin
      data  = sel ? data1 : data0;
      valid = sel ? valid1 : valid0;
      last  = sel ? last1 : last0;
   end
endmodule

// File: rtl/mux_channel_arbiter.sv
// mux_channel_arbiter: two-requester round-robin arbiter over a shared 2:1 mux channel
// ports: clk, rst (async high); data/valid/last 0/1 in, ready0/1 out;
//        out_data/out_valid/out_last out, out_ready in; sel, busy out
module mux_channel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic             valid0,
   input  logic             valid1,
   input  logic             last0,
   input  logic             last1,
   output logic             ready0,
   output logic             ready1,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic             sel,
   output logic             busy
);
   localparam int CW = $clog2(MAX_BURST + 1);
   arb_state_t state, state_nx;
   logic prio, prio_nx, sel_q, sel_nx, pick, hs, rel, m_valid, m_last;
   logic [CW-1:0] cnt, cnt_nx;
   mux2_data_path #(.WIDTH(WIDTH)) u_dp (
      .sel(sel_q), .data0(data0), .data1(data1), .valid0(valid0), .valid1(valid1),
      .last0(last0), .last1(last1), .data(out_data), .valid(m_valid), .last(m_last)
   );
   always_comb begin
      pick      = (valid0 & valid1) ? prio : (valid1 ? SEL_CH1 : SEL_CH0);
      busy      = state != ARB_IDLE;
      sel       = sel_q;
      out_valid = busy & m_valid;
      out_last  = out_valid & (m_last | (cnt == CW'(MAX_BURST - 1)));
      ready0    = (state == ARB_GRANT0) & out_ready;
      ready1    = (state == ARB_GRANT1) & out_ready;
      hs        = out_valid & out_ready;
      rel       = hs & out_last;
      state_nx  = !busy ? ((valid0 | valid1) ? (pick == SEL_CH1 ? ARB_GRANT1 : ARB_GRANT0) : ARB_IDLE)
                        : (rel ? ARB_IDLE : state);
      sel_nx    = (!busy && (valid0 | valid1)) ? pick : sel_q;
      // the released requester loses the next tie
      prio_nx   = rel ? ~sel_q : prio;
      cnt_nx    = (!busy || rel) ? '0 : (hs ? cnt + 1'b1 : cnt);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ARB_IDLE;
         prio  <= SEL_CH0;
         sel_q <= SEL_CH0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         prio  <= prio_nx;
         sel_q <= sel_nx;
         cnt   <= cnt_nx;
      end
   end
endmodule

// File: doc/mux_channel_arbiter.md
# mux_channel_arbiter

Two-requester round-robin arbiter that shares a single 2:1 mux-based output channel. It drives the mux select, gates each requester's valid/ready handshake onto the shared channel, and holds a grant for a bounded burst. It sits between two streaming producers and one downstream consumer, and is the sequencing layer above the plain 2:1 mux datapath.

## Interface
Parameters:
- `WIDTH`, 8: data width of each channel.
- `MAX_BURST`, 4: maximum beats per grant; must be ≥1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data0` / `data1` in WIDTH: requester payloads.
- `valid0` / `valid1` in 1: requester has a beat.
- `last0` / `last1` in 1: the current beat ends the requester's packet.
- `ready0` / `ready1` out 1: beat accepted from that requester.
- `out_data` out WIDTH: shared channel payload (mux output).
- `out_valid` out 1: shared channel beat valid.
- `out_last` out 1: the current beat is the final beat of this grant.
- `out_ready` in 1: consumer accepts the beat.
- `sel` out 1: current mux select (0 = requester 0, 1 = requester 1).
- `busy` out 1: a grant is active.

## Operation
- State machine has three states: IDLE, GRANT0 and GRANT1. A round-robin pointer `prio` records which requester wins a tie.
- **IDLE:**
  - If both `valid0` and `valid1` are asserted, grant the requester indicated by `prio`.
  - Otherwise, grant whichever requester is valid.
  - If neither is valid, stay in IDLE.
- **GRANTx:**
  - `sel`=x.
  - `out_data`=`data_x`.
  - `out_valid`=`valid_x`.
  - `ready_x`=`out_ready`.
  - The other requester's ready is 0.
- **Handshake:** a beat transfers when `out_valid` and `out_ready` are both high. The beat counter `cnt` increments on each handshake. `cnt` is $clog2(MAX_BURST+1) bits wide and is cleared on entering a grant.
- **out_last** = `out_valid` & (`last_x` | `cnt`==MAX_BURST-1).
- **Release:** on a handshake with `out_last` high:
  - Next state is IDLE.
  - `prio` becomes the other requester (!x).
  - `cnt` clears.
- A grant is never released without a handshake. If `valid_x` drops mid-grant, the grant is held with `out_valid`=0.
- In IDLE:
  - `out_valid`=0, `ready0`=`ready1`=0, `out_last`=0.
  - `sel` holds its last value.
  - `out_data` follows `sel`.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - State IDLE, `prio`=0, `cnt`=0.
  - `sel`=0, `busy`=0.
  - `out_valid`=0, `out_last`=0, `ready0`=`ready1`=0.
  - `out_data`=`data0`.
- **Grant latency:** if `valid_x` is high in IDLE at edge N, GRANTx is registered at edge N+1, and the first beat can transfer in the cycle after N+1.
- **Re-arbitration:** after release there is one mandatory IDLE cycle before the next grant. With both requesters streaming continuously, throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- **Combinational paths:**
  - `out_valid`, `out_data` and `out_last` are combinational from the granted requester's inputs and registered state.
  - `ready_x` is combinational from `out_ready`.
  - There is no path from `out_ready` to `out_valid`.
- **Simultaneous events:** if the release handshake and a new valid from the same requester coincide, the requester still goes back to IDLE. That requester loses the next tie because `prio` has flipped.
- **Reset mid-grant:** state, `prio` and `cnt` clear immediately and asynchronously, and all readies and `out_valid` drop in the same cycle. An in-flight beat is dropped, not replayed.

## Structure
- Package `mux_arb_pkg` holds:
  - The state encoding (`ARB_IDLE`=2'd0, `ARB_GRANT0`=2'd1, `ARB_GRANT1`=2'd2).
  - The select constants `SEL_CH0`/`SEL_CH1`.
- Sub-module `mux2_data_path` (parameter WIDTH) contains the pure 2:1 select of data, valid and last. The FSM, counter, `prio` and ready gating live in `mux_channel_arbiter`.

## Test plan
- **Reset check:** assert `rst` with `valid0`=`valid1`=1. Required: `out_valid`=0, `ready0`=`ready1`=0, `sel`=0, `busy`=0. After deassert, GRANT0 is taken because `prio`=0.
- **Solo requester:** `valid1`=1, `data1`=8'hA5, `last1`=1 on the first beat, `out_ready`=1.
  - Required: `sel`=1 and `out_data`=8'hA5 one cycle after the valid is seen in IDLE.
  - `out_last`=1 on that beat, then IDLE and `prio`=0.
- **Contention with MAX_BURST=4:** both requesters valid continuously, `last` never asserted, `out_ready`=1.
  - Required sequence: 4 beats from ch0, 1 idle cycle, 4 beats from ch1, 1 idle cycle, repeating.
  - `out_last` is high on beats 4, 8, and so on.
- **Backpressure:** during GRANT0, `out_ready`=0 for 3 cycles.
  - Required: `ready0`=0, `cnt` holds, `out_data` stable.
  - Grant is held and `valid1` is ignored.
- **Requester stall:** `valid0` drops for 2 cycles mid-burst.
  - Required: `out_valid`=0, state stays GRANT0, `cnt` unchanged.
  - Transfer resumes when `valid0` returns.
- **Reset mid-burst:** after 2 beats of GRANT1, pulse `rst` for 1 cycle.
  - Required: immediate IDLE, `prio`=0, `cnt`=0.
  - The next contention is won by ch0.
